// File: rtl/drive_mode_hub.sv
// drive_mode_hub: selects one of NUM_MODES driving-mode channels and registers its
// state/moving_state. Outputs are held idle for a settle window after power-up or a mode
// switch. Sends periodic and on-change command frames to the UART and latches detector
// frames from it.
// Optional feature: define DETECTOR_TIMEOUT_EN to mark detectors stale after DET_TIMEOUT
// cycles without rx_valid.
module drive_mode_hub #(
  parameter int unsigned NUM_MODES     = 3,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned TX_PERIOD     = 100000,
  parameter int unsigned DET_TIMEOUT   = 1000000
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   power,
  input  logic [1:0]             mode_sel,
  input  logic [2*NUM_MODES-1:0] mode_state,
  input  logic [4*NUM_MODES-1:0] mode_moving,
  output logic [1:0]             state,
  output logic [3:0]             moving_state,
  output logic [2:0]             state_light,
  output logic [3:0]             moving_light,
  output logic                   switching,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [3:0]             detectors,
  output logic                   det_stale
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TX_PERIOD);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TX_LAST     = TW'(TX_PERIOD - 1);

  if (NUM_MODES < 1 || NUM_MODES > 4) begin : g_bad_modes
    $error("drive_mode_hub: NUM_MODES must be 1..4");
  end
  if (SETTLE_CYCLES < 1 || TX_PERIOD < 2 || DET_TIMEOUT < 1) begin : g_bad_timing
    $error("drive_mode_hub: SETTLE_CYCLES>=1, TX_PERIOD>=2, DET_TIMEOUT>=1 required");
  end

  typedef enum logic [1:0] {ST_OFF, ST_SETTLE, ST_RUN} fsm_t;

  fsm_t          fsm;
  logic [1:0]    cur_mode;
  logic [SW-1:0] settle_cnt;
  logic [1:0]    sel_state;
  logic [3:0]    sel_moving;
  logic          sel_ok;

  logic [TW-1:0] tx_cnt;
  logic          tx_pend;
  logic [3:0]    moving_prev;
  logic          tx_req;
  logic          tx_hs;
  logic [7:0]    frame;

  logic          unused_rx_hi;
  assign unused_rx_hi = ^rx_data[7:4];

  assign sel_ok = (32'(mode_sel) < NUM_MODES);

  // Channel mux for the committed mode; out-of-range indices read as idle.
  always_comb begin
    sel_state  = '0;
    sel_moving = '0;
    for (int unsigned i = 0; i < NUM_MODES; i++) begin
      if (cur_mode == 2'(i)) begin
        sel_state  = mode_state[2*i +: 2];
        sel_moving = mode_moving[4*i +: 4];
      end
    end
  end

  // Mode FSM: power gating, settle window, registered channel outputs.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      fsm          <= ST_OFF;
      cur_mode     <= '0;
      settle_cnt   <= '0;
      state        <= '0;
      moving_state <= '0;
      switching    <= 1'b0;
    end else if (!power) begin
      fsm          <= ST_OFF;
      settle_cnt   <= '0;
      state        <= '0;
      moving_state <= '0;
      switching    <= 1'b0;
    end else begin
      state        <= '0;
      moving_state <= '0;
      case (fsm)
        ST_OFF: begin
          fsm        <= ST_SETTLE;
          cur_mode   <= mode_sel;
          settle_cnt <= SETTLE_LOAD;
          switching  <= 1'b1;
        end
        ST_SETTLE: begin
          // An invalid selection freezes the window until a real channel is chosen.
          if (!sel_ok) begin
            cur_mode <= mode_sel;
          end else if (mode_sel != cur_mode) begin
            cur_mode   <= mode_sel;
            settle_cnt <= SETTLE_LOAD;
          end else if (settle_cnt == '0) begin
            fsm          <= ST_RUN;
            switching    <= 1'b0;
            state        <= sel_state;
            moving_state <= sel_moving;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        ST_RUN: begin
          if (mode_sel != cur_mode) begin
            fsm        <= ST_SETTLE;
            cur_mode   <= mode_sel;
            settle_cnt <= SETTLE_LOAD;
            switching  <= 1'b1;
          end else begin
            state        <= sel_state;
            moving_state <= sel_moving;
          end
        end
        default: begin
          fsm       <= ST_OFF;
          switching <= 1'b0;
        end
      endcase
    end
  end

  // State indicator decoded from the registered state; dark while unpowered.
  always_comb begin
    state_light = '0;
    if (fsm != ST_OFF) begin
      case (state)
        2'd0:    state_light = 3'b001;
        2'd1:    state_light = 3'b010;
        2'd2:    state_light = 3'b100;
        default: state_light = 3'b111;
      endcase
    end
  end

  assign moving_light = moving_state;

  assign tx_req = (tx_cnt == TX_LAST) || (moving_state != moving_prev);
  assign tx_hs  = tx_valid && tx_ready;
  assign frame  = {2'b10, cur_mode, moving_state};

  // TX framer: one outstanding frame, later requests collapse into a single follow-up.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      tx_cnt      <= '0;
      tx_pend     <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      moving_prev <= '0;
    end else begin
      moving_prev <= moving_state;
      tx_cnt      <= (tx_hs || tx_cnt == TX_LAST) ? '0 : tx_cnt + TW'(1);
      if (!tx_valid) begin
        if (tx_req || tx_pend) begin
          tx_valid <= 1'b1;
          tx_data  <= frame;
          tx_pend  <= 1'b0;
        end
      end else if (tx_ready) begin
        // Follow-up frame goes out back-to-back with fresh contents.
        if (tx_req || tx_pend) begin
          tx_data <= frame;
          tx_pend <= 1'b0;
        end else begin
          tx_valid <= 1'b0;
        end
      end else if (tx_req) begin
        tx_pend <= 1'b1;
      end
    end
  end

`ifdef DETECTOR_TIMEOUT_EN
  localparam int unsigned DW = $clog2(DET_TIMEOUT + 1);
  logic [DW-1:0] silence;

  // Detector latch with rx-silence watchdog; stale data reads as all blocked.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      silence   <= '0;
      detectors <= '0;
      det_stale <= 1'b0;
    end else if (rx_valid) begin
      silence   <= '0;
      detectors <= rx_data[3:0];
      det_stale <= 1'b0;
    end else if (silence != DW'(DET_TIMEOUT)) begin
      silence <= silence + DW'(1);
      if (silence == DW'(DET_TIMEOUT - 1)) begin
        detectors <= 4'b1111;
        det_stale <= 1'b1;
      end
    end
  end
`else
  // Detector latch: holds the last received frame indefinitely.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      detectors <= '0;
    end else if (rx_valid) begin
      detectors <= rx_data[3:0];
    end
  end

  assign det_stale = 1'b0;
`endif

endmodule

// File: tb/tb_drive_mode_hub.sv
// Testbench for drive_mode_hub: directed scenarios followed by randomized traffic, all
// checked cycle by cycle against a behavioural model of the mode hub.
module tb_drive_mode_hub;

  localparam int unsigned NM = 3;
  localparam int unsigned SC = 16;
  localparam int unsigned TP = 40;
  localparam int unsigned DT = 50;
  localparam int unsigned SWID = 2 * NM;
  localparam int unsigned MWID = 4 * NM;

  logic            clk = 1'b0;
  logic            rst, power, tx_ready, rx_valid;
  logic [1:0]      mode_sel;
  logic [SWID-1:0] mode_state;
  logic [MWID-1:0] mode_moving;
  logic [7:0]      rx_data;
  logic [1:0]      state;
  logic [3:0]      moving_state, moving_light, detectors;
  logic [2:0]      state_light;
  logic            switching, tx_valid, det_stale;
  logic [7:0]      tx_data;

  always #5 clk = ~clk;

  drive_mode_hub #(
    .NUM_MODES(NM),
    .SETTLE_CYCLES(SC),
    .TX_PERIOD(TP),
    .DET_TIMEOUT(DT)
  ) dut (
    .sys_clk(clk), .rst(rst), .power(power), .mode_sel(mode_sel),
    .mode_state(mode_state), .mode_moving(mode_moving),
    .state(state), .moving_state(moving_state), .state_light(state_light),
    .moving_light(moving_light), .switching(switching),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .detectors(detectors), .det_stale(det_stale)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit         m_on = 0, m_run = 0, m_sw = 0, m_txv = 0, m_pend = 0, m_stale = 0;
  int         m_age = 0, m_period = 0, m_quiet = 0;
  logic [1:0] m_cur = '0, m_state = '0;
  logic [3:0] m_mov = '0, m_mov_prev = '0, m_det = '0;
  logic [7:0] m_txd = '0;

  function automatic logic [1:0] ch_state(input logic [1:0] idx);
    return 2'(mode_state >> (2 * int'(idx)));
  endfunction

  function automatic logic [3:0] ch_moving(input logic [1:0] idx);
    return 4'(mode_moving >> (4 * int'(idx)));
  endfunction

  function automatic void model_step();
    bit         req, hs;
    logic [7:0] frm;
    if (rst) begin
      m_on = 0; m_run = 0; m_sw = 0; m_txv = 0; m_pend = 0; m_stale = 0;
      m_age = 0; m_period = 0; m_quiet = 0;
      m_cur = '0; m_state = '0; m_mov = '0; m_mov_prev = '0; m_det = '0; m_txd = '0;
      return;
    end
    req = (m_period == TP - 1) || (m_mov != m_mov_prev);
    hs  = m_txv && tx_ready;
    frm = {2'b10, m_cur, m_mov};
    m_period = (hs || m_period == TP - 1) ? 0 : m_period + 1;
    if (!m_txv) begin
      if (req) begin m_txv = 1; m_txd = frm; end
    end else if (tx_ready) begin
      if (req || m_pend) begin m_txd = frm; m_pend = 0; end
      else m_txv = 0;
    end else if (req) begin
      m_pend = 1;
    end
    m_mov_prev = m_mov;

    if (!power) begin
      m_on = 0; m_run = 0; m_sw = 0; m_state = 0; m_mov = 0;
    end else if (!m_on) begin
      m_on = 1; m_run = 0; m_sw = 1; m_cur = mode_sel; m_age = 0; m_state = 0; m_mov = 0;
    end else if (!m_run) begin
      m_state = 0; m_mov = 0;
      if (int'(mode_sel) >= NM) m_cur = mode_sel;
      else if (mode_sel != m_cur) begin m_cur = mode_sel; m_age = 0; end
      else if (m_age == SC - 1) begin
        m_run = 1; m_sw = 0; m_state = ch_state(m_cur); m_mov = ch_moving(m_cur);
      end else m_age++;
    end else begin
      if (mode_sel != m_cur) begin
        m_run = 0; m_sw = 1; m_cur = mode_sel; m_age = 0; m_state = 0; m_mov = 0;
      end else begin
        m_state = ch_state(m_cur); m_mov = ch_moving(m_cur);
      end
    end

`ifdef DETECTOR_TIMEOUT_EN
    if (rx_valid) begin
      m_det = rx_data[3:0]; m_stale = 0; m_quiet = 0;
    end else begin
      if (m_quiet < DT) m_quiet++;
      if (m_quiet == DT) begin m_det = 4'hF; m_stale = 1; end
    end
`else
    if (rx_valid) m_det = rx_data[3:0];
`endif
  endfunction

  task automatic compare_all();
    logic [2:0] exp_light;
    exp_light = !m_on ? 3'b000 : (m_state == 2'd3 ? 3'b111 : 3'(1 << m_state));
    check("state", state, m_state);
    check("moving_state", moving_state, m_mov);
    check("moving_light", moving_light, m_mov);
    check("state_light", state_light, exp_light);
    check("switching", switching, m_sw);
    check("tx_valid", tx_valid, m_txv);
    check("tx_data", tx_data, m_txd);
    check("detectors", detectors, m_det);
    check("det_stale", det_stale, m_stale);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    int         n;
    logic [3:0] x1, x2, x3;
    rst = 1; power = 0; mode_sel = '0; mode_state = '0; mode_moving = '0;
    tx_ready = 0; rx_valid = 0; rx_data = '0;
    @(negedge clk);
    tick();
    tick();
    check("reset_tx_valid", tx_valid, 0);
    check("reset_state_light", state_light, 0);

    // Power-up into channel 0
    rst = 0; power = 1; mode_sel = 2'd0; tx_ready = 1;
    mode_state[1:0] = 2'b01; mode_moving[3:0] = 4'b1000;
    tick();
    n = 0;
    while (switching && n < 40) begin n++; tick(); end
    check("pwrup_settle_len", n, SC);
    check("pwrup_state", state, 2'b01);
    check("pwrup_moving", moving_state, 4'b1000);
    check("pwrup_light", state_light, 3'b010);

    // Switch to channel 2 while running
    mode_state[5:4] = 2'b10; mode_moving[11:8] = 4'b0100; mode_sel = 2'd2;
    tick();
    check("sw2_moving_idle", moving_state, 0);
    check("sw2_switching", switching, 1);
    repeat (SC) tick();
    check("sw2_state", state, 2'b10);
    check("sw2_moving", moving_state, 4'b0100);
    check("sw2_light", state_light, 3'b100);

    // Out-of-range selection parks the hub in settle
    mode_state[3:2] = 2'b11; mode_moving[7:4] = 4'b0011; mode_sel = 2'd3;
    tick();
    repeat (30) tick();
    check("bad_sel_switching", switching, 1);
    check("bad_sel_moving", moving_state, 0);
    mode_sel = 2'd1;
    repeat (SC + 1) tick();
    check("sel1_state", state, 2'b11);
    check("sel1_light", state_light, 3'b111);

    // TX back-pressure: frame held stable, later change collapses into one follow-up
    x1 = ~mode_moving[7:4];
    x2 = x1 ^ 4'h1;
    x3 = x2 ^ 4'h2;
    mode_moving[7:4] = x1;
    tick(); tick();
    n = 0;
    while (tx_valid && n < 10) begin n++; tick(); end
    check("tx_sync_idle", tx_valid, 0);
    tx_ready = 0; mode_moving[7:4] = x2;
    tick(); tick();
    check("tx_issue_valid", tx_valid, 1);
    check("tx_issue_data", tx_data, {2'b10, 2'b01, x2});
    mode_moving[7:4] = x3;
    repeat (5) begin
      tick();
      check("tx_stall_valid", tx_valid, 1);
      check("tx_stall_data", tx_data, {2'b10, 2'b01, x2});
    end
    tx_ready = 1;
    tick();
    check("tx_refire_valid", tx_valid, 1);
    check("tx_refire_data", tx_data, {2'b10, 2'b01, x3});
    tick();
    check("tx_drained", tx_valid, 0);

    // Reset in the middle of a pending frame
    tx_ready = 0; mode_moving[7:4] = x1;
    tick(); tick();
    check("rst_pre_valid", tx_valid, 1);
    rst = 1;
    tick();
    check("rst_mid_tx_valid", tx_valid, 0);
    check("rst_mid_tx_data", tx_data, 0);
    check("rst_mid_state", state, 0);
    check("rst_mid_switching", switching, 0);
    rst = 0; tx_ready = 1;

    // Detector latch
    rx_valid = 1; rx_data = 8'hA3;
    tick();
    rx_valid = 0;
    check("rx_latch", detectors, 4'h3);
`ifdef DETECTOR_TIMEOUT_EN
    repeat (DT - 1) tick();
    check("rx_not_stale_yet", det_stale, 0);
    check("rx_hold_before_timeout", detectors, 4'h3);
    tick();
    check("rx_stale", det_stale, 1);
    check("rx_forced_blocked", detectors, 4'hF);
    rx_valid = 1; rx_data = 8'h05;
    tick();
    rx_valid = 0;
    check("rx_recover_det", detectors, 4'h5);
    check("rx_recover_stale", det_stale, 0);
`else
    repeat (DT + 10) tick();
    check("rx_hold_long", detectors, 4'h3);
    check("rx_never_stale", det_stale, 0);
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(299) == 0);
      if (power) power = ($urandom_range(149) != 0);
      else       power = ($urandom_range(9) == 0);
      if ($urandom_range(39) == 0) mode_sel = 2'($urandom_range(3));
      if ($urandom_range(19) == 0) mode_state = SWID'($urandom);
      if ($urandom_range(19) == 0) mode_moving = MWID'($urandom);
      tx_ready = ($urandom_range(2) != 0);
      rx_valid = ($urandom_range(79) == 0);
      rx_data  = 8'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
